// File: rtl/async_fifo_gen.sv
// async_fifo_gen: dual-clock FIFO with Gray-coded pointer crossing.
//   Write side (wclk): data_in, put -> full, almost_full, wr_level, overflow (sticky).
//   Read side  (rclk): get -> data_out, empty, almost_empty, rd_level, underflow (sticky).
//   reset is synchronous, active-high and sampled independently in each domain.
//   FWFT=0 gives a registered 1-cycle read; FWFT=1 presents the head word while !empty.
module async_fifo_gen #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_THR   = 6,
  parameter int AEMPTY_THR  = 2,
  parameter int FWFT        = 0
) (
  input  logic                  rclk,
  input  logic                  wclk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  put,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  input  logic                  get,
  output logic [WIDTH-1:0]      data_out,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [PW-1:0] ptr_t;

  // Inverting the top two Gray bits of the read pointer yields the Gray
  // code of (read pointer + DEPTH), i.e. the write position that means full.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (PW - 2);
  localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THR);
  localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THR);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int unsigned i = 1; i < PW; i++) begin
      b[PW-1-i] = b[PW-i] ^ g[PW-1-i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wr_bin, wr_gray, wr_bin_next, wr_gray_next;
  ptr_t rd_bin_wsync, wr_level_next;
  ptr_t rd_gray_wsync [SYNC_STAGES];
  logic wr_en;

  always_comb begin
    wr_en         = put && !full;
    wr_bin_next   = wr_bin + ptr_t'(wr_en);
    wr_gray_next  = bin2gray(wr_bin_next);
    rd_bin_wsync  = gray2bin(rd_gray_wsync[SYNC_STAGES-1]);
    wr_level_next = wr_bin_next - rd_bin_wsync;
  end

  always_ff @(posedge wclk) begin
    if (reset) begin
      wr_bin        <= '0;
      wr_gray       <= '0;
      rd_gray_wsync <= '{default: '0};
      full          <= 1'b0;
      almost_full   <= 1'b0;
      wr_level      <= '0;
      overflow      <= 1'b0;
    end else begin
      wr_bin           <= wr_bin_next;
      wr_gray          <= wr_gray_next;
      rd_gray_wsync[0] <= rd_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rd_gray_wsync[i] <= rd_gray_wsync[i-1];
      end
      full        <= (wr_gray_next == (rd_gray_wsync[SYNC_STAGES-1] ^ FULL_MASK));
      wr_level    <= wr_level_next;
      almost_full <= (wr_level_next >= AFULL_LVL);
      if (put && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_en && !reset) mem[wr_bin[ADDR_WIDTH-1:0]] <= data_in;
  end

  // ---------------- read domain ----------------
  ptr_t rd_bin, rd_gray, rd_bin_next, rd_gray_next;
  ptr_t wr_bin_rsync, rd_level_next;
  ptr_t wr_gray_rsync [SYNC_STAGES];
  logic rd_en;

  always_comb begin
    rd_en         = get && !empty;
    rd_bin_next   = rd_bin + ptr_t'(rd_en);
    rd_gray_next  = bin2gray(rd_bin_next);
    wr_bin_rsync  = gray2bin(wr_gray_rsync[SYNC_STAGES-1]);
    rd_level_next = wr_bin_rsync - rd_bin_next;
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      rd_bin        <= '0;
      rd_gray       <= '0;
      wr_gray_rsync <= '{default: '0};
      empty         <= 1'b1;
      almost_empty  <= 1'b1;
      rd_level      <= '0;
      underflow     <= 1'b0;
    end else begin
      rd_bin           <= rd_bin_next;
      rd_gray          <= rd_gray_next;
      wr_gray_rsync[0] <= wr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        wr_gray_rsync[i] <= wr_gray_rsync[i-1];
      end
      empty        <= (rd_gray_next == wr_gray_rsync[SYNC_STAGES-1]);
      rd_level     <= rd_level_next;
      almost_empty <= (rd_level_next <= AEMPTY_LVL);
      if (get && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      always_ff @(posedge rclk) begin
        if (reset)      data_out <= '0;
        else if (rd_en) data_out <= mem[rd_bin[ADDR_WIDTH-1:0]];
      end
    end else begin : g_fwft_read
      // Head word is addressed by the registered read pointer, so it is
      // stable for the whole rclk cycle; forced to 0 while empty.
      always_comb begin
        data_out = empty ? '0 : mem[rd_bin[ADDR_WIDTH-1:0]];
      end
    end
  endgenerate

endmodule

// File: tb/tb_async_fifo_gen.sv
`timescale 1ns/1ps
module tb_async_fifo_gen;

  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int SS    = 2;
  localparam int DEPTH = 8;
  localparam int NWORDS = 1000;

  logic rclk = 1'b0, wclk = 1'b0, reset = 1'b1, put = 1'b0, get = 1'b0;
  logic [7:0] data_in = '0;

  logic full0, af0, of0, em0, ae0, uf0;
  logic [3:0] wl0, rl0;
  logic [7:0] do0;
  logic full1, af1, of1, em1, ae1, uf1;
  logic [3:0] wl1, rl1;
  logic [7:0] do1;

  realtime whalf = 5.0;
  realtime rhalf = 8.5;
  always #(whalf) wclk = ~wclk;
  always #(rhalf) rclk = ~rclk;

  async_fifo_gen #(.WIDTH(8), .ADDR_WIDTH(3), .SYNC_STAGES(SS), .AFULL_THR(AF),
                   .AEMPTY_THR(AE), .FWFT(0)) dut0 (
    .rclk(rclk), .wclk(wclk), .reset(reset), .data_in(data_in), .put(put),
    .full(full0), .almost_full(af0), .wr_level(wl0), .overflow(of0),
    .get(get), .data_out(do0), .empty(em0), .almost_empty(ae0),
    .rd_level(rl0), .underflow(uf0));

  async_fifo_gen #(.WIDTH(8), .ADDR_WIDTH(3), .SYNC_STAGES(SS), .AFULL_THR(AF),
                   .AEMPTY_THR(AE), .FWFT(1)) dut1 (
    .rclk(rclk), .wclk(wclk), .reset(reset), .data_in(data_in), .put(put),
    .full(full1), .almost_full(af1), .wr_level(wl1), .overflow(of1),
    .get(get), .data_out(do1), .empty(em1), .almost_empty(ae1),
    .rd_level(rl1), .underflow(uf1));

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] q[$];
  bit exp_of, exp_uf, wdone;
  int pushed, popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge rclk);
    reset = 1'b1; put = 1'b0; get = 1'b0;
    repeat (SS + 4) @(negedge wclk);
    repeat (SS + 4) @(negedge rclk);
    reset = 1'b0;
    @(negedge rclk);
    q.delete();
    exp_of = 1'b0;
    exp_uf = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge wclk);
    put = 1'b1; data_in = d;
    @(negedge wclk);
    put = 1'b0;
  endtask

  task automatic rd();
    @(negedge rclk);
    get = 1'b1;
    @(negedge rclk);
    get = 1'b0;
  endtask

  task automatic wait_nonempty(input string tag);
    int n = 0;
    while (em0 && n < 50) begin
      @(negedge rclk);
      n++;
    end
    chk(tag, 32'(em0), 0);
  endtask

  task automatic wait_notfull(input string tag);
    int n = 0;
    while (full0 && n < 50) begin
      @(negedge wclk);
      n++;
    end
    chk(tag, 32'(full0), 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] d;
    int n;

    // ---- reset values ----
    do_reset();
    chk("rst_empty", 32'(em0), 1);
    chk("rst_aempty", 32'(ae0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_afull", 32'(af0), 0);
    chk("rst_wlevel", 32'(wl0), 0);
    chk("rst_rlevel", 32'(rl0), 0);
    chk("rst_overflow", 32'(of0), 0);
    chk("rst_underflow", 32'(uf0), 0);
    chk("rst_dout", 32'(do0), 0);
    chk("rst_fwft_empty", 32'(em1), 1);
    chk("rst_fwft_dout", 32'(do1), 0);

    // ---- fill to full, thresholds, overflow ----
    for (int i = 1; i <= DEPTH; i++) begin
      d = 8'(8'h11 * i);
      wr(d);
      chk("fill_wlevel", 32'(wl0), 32'(i));
      chk("fill_afull", 32'(af0), 32'(i >= AF));
      chk("fill_full", 32'(full0), 32'(i == DEPTH));
    end
    wr(8'h99);
    chk("ovf_flag", 32'(of0), 1);
    chk("ovf_full", 32'(full0), 1);
    chk("ovf_wlevel", 32'(wl0), DEPTH);

    // ---- drain in order ----
    wait_nonempty("fill_visible");
    repeat (SS + 3) @(negedge rclk);
    chk("full_rlevel", 32'(rl0), DEPTH);
    chk("full_aempty", 32'(ae0), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      d = 8'(8'h11 * i);
      chk("fwft_head", 32'(do1), 32'(d));
      rd();
      chk("drain_data", 32'(do0), 32'(d));
      chk("drain_rlevel", 32'(rl0), 32'(DEPTH - i));
      chk("drain_aempty", 32'(ae0), 32'((DEPTH - i) <= AE));
    end
    chk("drain_empty", 32'(em0), 1);

    // ---- underflow ----
    rd();
    chk("udf_flag", 32'(uf0), 1);
    chk("udf_empty", 32'(em0), 1);
    chk("udf_rlevel", 32'(rl0), 0);
    wait_notfull("full_release");
    repeat (SS + 3) @(negedge wclk);
    chk("release_wlevel", 32'(wl0), 0);
    chk("release_afull", 32'(af0), 0);

    // ---- single word latency + FWFT presentation ----
    wr(8'hA5);
    n = 0;
    while (em0 && n < SS + 2) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk("a5_latency", 32'(em0), 0);
    @(negedge rclk);
    chk("a5_fwft_empty", 32'(em1), 0);
    chk("a5_fwft_dout", 32'(do1), 32'h A5);
    rd();
    chk("a5_data", 32'(do0), 32'hA5);
    chk("a5_empty", 32'(em0), 1);
    chk("udf_sticky", 32'(uf0), 1);

    // ---- reset with contents discards them ----
    for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
    wait_nonempty("five_visible");
    do_reset();
    chk("mid_rst_empty", 32'(em0), 1);
    chk("mid_rst_rlevel", 32'(rl0), 0);
    chk("mid_rst_wlevel", 32'(wl0), 0);
    chk("mid_rst_aempty", 32'(ae0), 1);
    chk("mid_rst_udf", 32'(uf0), 0);
    chk("mid_rst_ovf", 32'(of0), 0);
    wr(8'h3C);
    wait_nonempty("3c_visible");
    chk("3c_fwft", 32'(do1), 32'h3C);
    rd();
    chk("3c_data", 32'(do0), 32'h3C);
    chk("3c_empty", 32'(em0), 1);

    // ---- randomized traffic at 1:3 and 3:1 clock ratios ----
    for (int ph = 0; ph < 2; ph++) begin
      whalf = (ph == 0) ? 5.0 : 15.0;
      rhalf = (ph == 0) ? 15.0 : 5.0;
      do_reset();
      wdone = 1'b0;
      pushed = 0;
      popped = 0;
      fork
        begin : writer
          int wcyc;
          bit p;
          logic [7:0] wd;
          wcyc = 0;
          while (pushed < NWORDS && wcyc < 20000) begin
            @(negedge wclk);
            wcyc++;
            chk("rand_afull_thr", 32'(af0), 32'(32'(wl0) >= AF));
            chk("rand_wlevel_max", 32'(32'(wl0) <= DEPTH), 1);
            p = ($urandom_range(0, 3) != 0);
            wd = 8'($urandom);
            put = p;
            data_in = wd;
            if (p) begin
              if (!full0) begin
                q.push_back(wd);
                pushed++;
              end else begin
                exp_of = 1'b1;
              end
            end
          end
          @(negedge wclk);
          put = 1'b0;
          wdone = 1'b1;
        end
        begin : reader
          int rcyc;
          bit pend, g;
          logic [7:0] pexp;
          rcyc = 0;
          pend = 1'b0;
          pexp = '0;
          while (rcyc < 20000) begin
            @(negedge rclk);
            rcyc++;
            if (pend) begin
              chk("rand_data", 32'(do0), 32'(pexp));
              pend = 1'b0;
            end
            chk("rand_aempty_thr", 32'(ae0), 32'(32'(rl0) <= AE));
            chk("rand_rlevel_bound", 32'(32'(rl0) <= q.size()), 1);
            if (q.size() == 0) chk("rand_empty_model", 32'(em0), 1);
            if (!em1 && q.size() > 0) chk("rand_fwft_head", 32'(do1), 32'(q[0]));
            if (wdone && q.size() == 0) break;
            g = ($urandom_range(0, 3) != 0);
            get = g;
            if (g) begin
              if (!em0) begin
                pexp = q.pop_front();
                popped++;
                pend = 1'b1;
              end else begin
                exp_uf = 1'b1;
              end
            end
          end
          get = 1'b0;
        end
      join
      chk("rand_pushed", 32'(pushed), NWORDS);
      chk("rand_popped", 32'(popped), NWORDS);
      chk("rand_drained", 32'(q.size()), 0);
      chk("rand_overflow", 32'(of0), 32'(exp_of));
      chk("rand_underflow", 32'(uf0), 32'(exp_uf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
